m_cp0: RTL and testbench

Coprocessor-0 unit for the M stage of the five-stage MIPS pipeline. Holds SR, Cause and EPC, and, when configured, BadVAddr. Arbitrates hardware interrupts against synchronous exceptions carried down the pipe, and services mfc0/mtc0/eret. Its `req` output flushes the M/W pipeline register and redirects fetch to `EXCPC`; its `dout` feeds `M_CP0_RD`.

---
 rtl/m_cp0_pkg.sv | 40 ++++
 rtl/m_cp0.sv | 113 +++++++++++
 tb/tb_m_cp0.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/m_cp0_pkg.sv
// Coprocessor-0 constants: register indices, exception codes, the exception
// vector, and the packed layouts of the SR and Cause fields that hold state.
package m_cp0_pkg;

  localparam logic [31:0] EXCPC        = 32'h0000_4180;

  localparam logic [4:0]  CP0_BADVADDR = 5'd8;
  localparam logic [4:0]  CP0_SR       = 5'd12;
  localparam logic [4:0]  CP0_CAUSE    = 5'd13;
  localparam logic [4:0]  CP0_EPC      = 5'd14;

  localparam logic [4:0]  EXC_INT      = 5'd0;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [4:0]  EXC_ADES     = 5'd5;
  localparam logic [4:0]  EXC_SYSCALL  = 5'd8;
  localparam logic [4:0]  EXC_RI       = 5'd10;
  localparam logic [4:0]  EXC_OV       = 5'd12;

  // Only the implemented bits are stored; everything else reads as zero.
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] sr_word(input sr_t s);
    return {16'h0000, s.im, 8'h00, s.exl, s.ie};
  endfunction

  function automatic logic [31:0] cause_word(input cause_t c);
    return {c.bd, 15'h0000, c.ip, 3'b000, c.exc_code, 2'b00};
  endfunction

endpackage

// File: rtl/m_cp0.sv
// M-stage coprocessor 0: SR/Cause/EPC, interrupt vs exception arbitration,
// mfc0/mtc0/eret. Define CP0_BADVADDR_EN to implement BadVAddr at index 8.
module m_cp0
  import m_cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a_rd,
  input  logic [4:0]  a_wr,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  exc_code,
  input  logic [31:0] badvaddr,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        req
);

  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        int_req, exc_req;

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;
`else
  logic        unused_badvaddr;
  assign unused_badvaddr = ^badvaddr;
`endif

  // The live hw_int lines are used, not IP, so an interrupt is taken the
  // same cycle it is raised.
  assign int_req = (|(hw_int & sr_q.im)) & sr_q.ie & ~sr_q.exl;
  assign exc_req = (exc_code != EXC_INT) & ~sr_q.exl;
  assign req     = reset & (int_req | exc_req);
  assign epc_out = reset ? epc_q : 32'h0;

  // NOTE: every next-state signal gets its hold value first, so no path
  // through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    sr_d        = sr_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    cause_d.ip  = hw_int;
`ifdef CP0_BADVADDR_EN
    badvaddr_d  = badvaddr_q;
`endif
    if (req) begin
      sr_d.exl         = 1'b1;
      cause_d.bd       = m_bd;
      cause_d.exc_code = int_req ? EXC_INT : exc_code;
      epc_d            = m_bd ? (m_pc - 32'd4) : m_pc;
`ifdef CP0_BADVADDR_EN
      if (!int_req && (exc_code == EXC_ADEL || exc_code == EXC_ADES))
        badvaddr_d = badvaddr;
`endif
    end else begin
      if (we) begin
        case (a_wr)
          CP0_SR: begin
            sr_d.im  = din[15:10];
            sr_d.exl = din[1];
            sr_d.ie  = din[0];
          end
          CP0_EPC: epc_d = {din[31:2], 2'b00};
          default: ;
        endcase
      end
      // eret applies after mtc0 so a same-edge SR write cannot re-set EXL.
      if (eret) sr_d.exl = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q       <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= '0;
`endif
    end else begin
      sr_q       <= sr_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= badvaddr_d;
`endif
    end
  end

  always_comb begin
    dout = 32'h0;
    if (reset) begin
      case (a_rd)
        CP0_SR:       dout = sr_word(sr_q);
        CP0_CAUSE:    dout = cause_word(cause_q);
        CP0_EPC:      dout = epc_q;
`ifdef CP0_BADVADDR_EN
        CP0_BADVADDR: dout = badvaddr_q;
`endif
        default:      dout = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_m_cp0.sv
// Scoreboard bench for m_cp0: directed stimulus queues expected dout/req/epc_out,
// a negedge monitor pops and compares.
module tb_m_cp0;

  logic        clk = 1'b1;
  logic        reset;
  logic [4:0]  a_rd, a_wr, exc_code;
  logic [31:0] din, m_pc, badvaddr;
  logic        we, m_bd, eret;
  logic [5:0]  hw_int;
  logic [31:0] dout, epc_out;
  logic        req;

  always #5 clk = ~clk;

  m_cp0 dut (
    .clk(clk), .reset(reset), .a_rd(a_rd), .a_wr(a_wr), .din(din), .we(we),
    .m_pc(m_pc), .m_bd(m_bd), .exc_code(exc_code), .badvaddr(badvaddr),
    .hw_int(hw_int), .eret(eret), .dout(dout), .epc_out(epc_out), .req(req)
  );

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [31:0] dv;
    logic        rq;
    logic [31:0] ep;
  } exp_t;

  exp_t exp_q[$];
  logic chk_stb = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

`ifdef CP0_BADVADDR_EN
  localparam logic [31:0] BV = 32'h0000_1003;
`else
  localparam logic [31:0] BV = 32'h0000_0000;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // Monitor: samples combinational outputs mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (chk_stb) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL scoreboard: strobe with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".dout"}, dout, e.dv);
        check({e.name, ".req"}, {31'h0, req}, {31'h0, e.rq});
        check({e.name, ".epc_out"}, epc_out, e.ep);
      end
    end
  end

  task automatic obs(input string nm, input logic [4:0] rd, input logic [31:0] dv,
                     input logic rq, input logic [31:0] ep);
    exp_t e;
    a_rd = rd;
    e.name = nm; e.rd = rd; e.dv = dv; e.rq = rq; e.ep = ep;
    exp_q.push_back(e);
    chk_stb = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_stb = 1'b0;
  endtask

  initial begin
    reset = 1'b0; a_rd = '0; a_wr = '0; din = '0; we = 1'b0; m_pc = '0;
    m_bd = 1'b0; exc_code = 5'd10; badvaddr = '0; hw_int = '0; eret = 1'b0;

    // Reset held for two edges with an exception code pending.
    obs("rst_sr", 12, 32'h0, 1'b0, 32'h0); tick();
    obs("rst_cause", 13, 32'h0, 1'b0, 32'h0); tick();
    reset = 1'b1; exc_code = 5'd0;
    obs("post_rst_epc", 14, 32'h0, 1'b0, 32'h0); tick();
    obs("post_rst_cause", 13, 32'h0, 1'b0, 32'h0); tick();

    // mtc0 SR, then interrupt.
    we = 1'b1; a_wr = 5'd12; din = 32'h0000_0401;
    obs("sr_raw", 12, 32'h0, 1'b0, 32'h0); tick();
    we = 1'b0;
    obs("sr_written", 12, 32'h0000_0401, 1'b0, 32'h0); tick();
    hw_int = 6'b000001; m_pc = 32'h3008;
    obs("int_req", 13, 32'h0, 1'b1, 32'h0); tick();
    m_pc = 32'h3100;
    obs("int_epc", 14, 32'h3008, 1'b0, 32'h3008); tick();
    obs("int_exl", 12, 32'h0000_0403, 1'b0, 32'h3008); tick();
    obs("int_cause", 13, 32'h0000_0400, 1'b0, 32'h3008); tick();

    // eret with the interrupt still pending; next cycle also carries an
    // exception and an mtc0 to EPC that must be dropped.
    eret = 1'b1;
    obs("eret_pre", 12, 32'h0000_0403, 1'b0, 32'h3008); tick();
    eret = 1'b0; exc_code = 5'd12; m_pc = 32'h3020;
    we = 1'b1; a_wr = 5'd14; din = 32'hdead_beef;
    obs("eret_repend", 12, 32'h0000_0401, 1'b1, 32'h3008); tick();
    exc_code = 5'd0; we = 1'b0;
    obs("int_over_exc_epc", 14, 32'h3020, 1'b0, 32'h3020); tick();
    obs("int_over_exc_code", 13, 32'h0000_0400, 1'b0, 32'h3020); tick();

    // eret together with mtc0 SR writing EXL=1: EXL must end at 0.
    hw_int = 6'b0; eret = 1'b1; we = 1'b1; a_wr = 5'd12; din = 32'h0000_0003;
    obs("eret_mtc0_pre", 12, 32'h0000_0403, 1'b0, 32'h3020); tick();
    eret = 1'b0; a_wr = 5'd14; din = 32'h0000_3017;
    obs("eret_mtc0_sr", 12, 32'h0000_0001, 1'b0, 32'h3020); tick();
    we = 1'b0;
    obs("epc_mask", 14, 32'h0000_3014, 1'b0, 32'h3014); tick();

    // Syscall in a delay slot, then nested exception and Cause write ignored.
    exc_code = 5'd8; m_pc = 32'h3010; m_bd = 1'b1;
    obs("sys_req", 13, 32'h0, 1'b1, 32'h3014); tick();
    exc_code = 5'd0; m_bd = 1'b0;
    obs("sys_cause", 13, 32'h8000_0020, 1'b0, 32'h300C); tick();
    exc_code = 5'd10;
    obs("nested_ign", 14, 32'h300C, 1'b0, 32'h300C); tick();
    exc_code = 5'd0; we = 1'b1; a_wr = 5'd13; din = 32'hffff_ffff;
    obs("nested_held", 13, 32'h8000_0020, 1'b0, 32'h300C); tick();
    we = 1'b0; eret = 1'b1;
    obs("cause_ro", 13, 32'h8000_0020, 1'b0, 32'h300C); tick();

    // AdEL captures BadVAddr (when implemented); mtc0 cannot overwrite it.
    eret = 1'b0; exc_code = 5'd4; badvaddr = 32'h0000_1003; m_pc = 32'h3040;
    obs("adel_req", 8, 32'h0, 1'b1, 32'h300C); tick();
    exc_code = 5'd0; we = 1'b1; a_wr = 5'd8; din = 32'h0000_ffff;
    obs("badvaddr", 8, BV, 1'b0, 32'h3040); tick();
    we = 1'b0; eret = 1'b1;
    obs("badvaddr_ro", 8, BV, 1'b0, 32'h3040); tick();

    // Delay-slot EPC wraps below zero.
    eret = 1'b0; exc_code = 5'd12; m_pc = 32'h0; m_bd = 1'b1;
    obs("unmapped", 5, 32'h0, 1'b1, 32'h3040); tick();
    exc_code = 5'd0; m_bd = 1'b0;
    obs("epc_wrap", 14, 32'hffff_fffc, 1'b0, 32'hffff_fffc); tick();
    obs("ov_cause", 13, 32'h8000_0030, 1'b0, 32'hffff_fffc); tick();
    eret = 1'b1;
    obs("eret2", 12, 32'h0000_0003, 1'b0, 32'hffff_fffc); tick();

    // Reset with an exception pending: reset wins, everything clears.
    eret = 1'b0; reset = 1'b0; exc_code = 5'd10;
    obs("rst_pend", 14, 32'h0, 1'b0, 32'h0); tick();
    reset = 1'b1; exc_code = 5'd0;
    obs("rst_epc", 14, 32'h0, 1'b0, 32'h0); tick();
    obs("rst_sr2", 12, 32'h0, 1'b0, 32'h0); tick();
    obs("rst_cause2", 13, 32'h0, 1'b0, 32'h0); tick();
    obs("rst_bv", 8, 32'h0, 1'b0, 32'h0); tick();

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
